// File: rtl/fetch_redirect_unit.sv
// Fetch PC generator with branch/jump redirect, pipeline flush generation,
// misaligned-target detection (sticky, halts fetch) and a saturating
// redirect counter.
//
// Fetch handshake: PCValid is the request valid and IMemReady is the ready.
// A fetch of address PC completes on a rising edge where PCValid=1 and
// IMemReady=1. While PCValid=1 and IMemReady=0 the PC is held stable. The
// only exception is a taken redirect, which abandons the pending fetch.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             NextPCSrc,
  input  logic [31:0]      BranchTarget,
  input  logic             Stall,
  input  logic             IMemReady,
  output logic [31:0]      PC,
  output logic             PCValid,
  output logic             FlushIFID,
  output logic             FlushIDEX,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] RedirectCount,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        pc_nxt;
  logic               err_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  // Debug view of the FSM state.
  assign fsm_state = state;

  // State, PC, error flag and counter registers; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      PC            <= RESET_PC;
      MisalignErr   <= 1'b0;
      RedirectCount <= '0;
    end else begin
      state         <= state_nxt;
      PC            <= pc_nxt;
      MisalignErr   <= err_nxt;
      RedirectCount <= cnt_nxt;
    end
  end

  // Next-state, next-PC and combinational outputs (flushes, PCValid).
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    err_nxt   = MisalignErr;
    cnt_nxt   = RedirectCount;
    PCValid   = 1'b0;
    FlushIFID = 1'b0;
    FlushIDEX = 1'b0;
    case (state)
      BOOT: begin
        // One idle cycle after reset; NextPCSrc is ignored here.
        state_nxt = RUN;
      end
      RUN: begin
        PCValid = 1'b1;
        if (NextPCSrc) begin
          // A taken redirect wins over Stall and IMemReady=0.
          FlushIFID = 1'b1;
          FlushIDEX = 1'b1;
          if (BranchTarget[1:0] != 2'b00) begin
            // Misaligned target: keep PC, latch the error and stop fetching.
            err_nxt   = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt = BranchTarget;
            if (RedirectCount != {CNT_W{1'b1}}) begin
              cnt_nxt = RedirectCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end else if (!Stall && IMemReady) begin
          // Fetch accepted: sequential advance, wraps modulo 2^32.
          pc_nxt = PC + 32'd4;
        end
      end
      HALT: begin
        // Everything frozen until reset.
        state_nxt = HALT;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed vector table, reset-during-HALT
// sequence, randomized run against a reference model, and a narrow-counter
// instance for saturation and PC wrap.
module tb_fetch_redirect_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (default parameters) ----------------
  logic        nps, st, rdy;
  logic [31:0] tgt;
  logic [31:0] pc;
  logic        valid, f_ifid, f_idex, err;
  logic [15:0] cnt;
  logic [1:0]  fsm1;

  fetch_redirect_unit dut (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(nps), .BranchTarget(tgt),
    .Stall(st), .IMemReady(rdy), .PC(pc), .PCValid(valid),
    .FlushIFID(f_ifid), .FlushIDEX(f_idex), .MisalignErr(err),
    .RedirectCount(cnt), .fsm_state(fsm1)
  );

  // ---------------- DUT 2 (2-bit counter) ----------------
  logic        nps2, st2, rdy2;
  logic [31:0] tgt2;
  logic [31:0] pc2;
  logic        valid2, f_ifid2, f_idex2, err2;
  logic [1:0]  cnt2;
  logic [1:0]  fsm2;

  fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(nps2), .BranchTarget(tgt2),
    .Stall(st2), .IMemReady(rdy2), .PC(pc2), .PCValid(valid2),
    .FlushIFID(f_ifid2), .FlushIDEX(f_idex2), .MisalignErr(err2),
    .RedirectCount(cnt2), .fsm_state(fsm2)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic apply(input logic a_nps, input logic [31:0] a_tgt, input logic a_st, input logic a_rdy);
    @(negedge clk);
    nps = a_nps; tgt = a_tgt; st = a_st; rdy = a_rdy;
    #1;
  endtask

  task automatic apply2(input logic a_nps, input logic [31:0] a_tgt, input logic a_st, input logic a_rdy);
    @(negedge clk);
    nps2 = a_nps; tgt2 = a_tgt; st2 = a_st; rdy2 = a_rdy;
    #1;
  endtask

  // Reset pulse asserted mid-cycle; outputs must go to reset values at once.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_flush", {30'b0, f_ifid, f_idex}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_cnt", {16'b0, cnt}, 32'h0);
    nps = 1'b0; st = 1'b0; rdy = 1'b1;
    nps2 = 1'b0; st2 = 1'b0; rdy2 = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        nps;
    logic [31:0] tgt;
    logic        st;
    logic        rdy;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic a_nps, input logic [31:0] a_tgt, input logic a_st,
                              input logic a_rdy, input logic [31:0] e_pc, input logic e_valid,
                              input logic e_flush, input logic e_err, input logic [15:0] e_cnt);
    vec_t v;
    v.nps = a_nps; v.tgt = a_tgt; v.st = a_st; v.rdy = a_rdy;
    v.pc = e_pc; v.valid = e_valid; v.flush = e_flush; v.err = e_err; v.cnt = e_cnt;
    return v;
  endfunction

  vec_t vecs[16];

  // ---------------- reference model state ----------------
  bit          m_boot;
  bit          m_halt;
  bit          m_err;
  logic [31:0] m_pc;
  int          m_cnt;
  localparam int CNT_MAX = (1 << 16) - 1;

  initial begin
    // Vector rows: inputs applied during a cycle, expected outputs that cycle.
    vecs[0]  = mk(1, 32'h40,  0, 1, 32'h0,   0, 0, 0, 0); // BOOT ignores redirect
    vecs[1]  = mk(0, 32'h0,   0, 1, 32'h0,   1, 0, 0, 0);
    vecs[2]  = mk(0, 32'h0,   0, 1, 32'h4,   1, 0, 0, 0);
    vecs[3]  = mk(0, 32'h0,   0, 1, 32'h8,   1, 0, 0, 0);
    vecs[4]  = mk(0, 32'h0,   0, 1, 32'hC,   1, 0, 0, 0);
    vecs[5]  = mk(1, 32'h100, 1, 1, 32'h10,  1, 1, 0, 0); // redirect beats Stall
    vecs[6]  = mk(1, 32'h20,  0, 0, 32'h100, 1, 1, 0, 1); // redirect beats !ready
    vecs[7]  = mk(0, 32'h0,   0, 0, 32'h20,  1, 0, 0, 2);
    vecs[8]  = mk(0, 32'h0,   0, 0, 32'h20,  1, 0, 0, 2);
    vecs[9]  = mk(0, 32'h0,   0, 0, 32'h20,  1, 0, 0, 2);
    vecs[10] = mk(0, 32'h0,   0, 1, 32'h20,  1, 0, 0, 2);
    vecs[11] = mk(0, 32'h0,   1, 1, 32'h24,  1, 0, 0, 2); // stall holds
    vecs[12] = mk(0, 32'h0,   0, 1, 32'h24,  1, 0, 0, 2);
    vecs[13] = mk(1, 32'h102, 0, 1, 32'h28,  1, 1, 0, 2); // misaligned
    vecs[14] = mk(1, 32'h200, 0, 1, 32'h28,  0, 0, 1, 2); // HALT ignores
    vecs[15] = mk(0, 32'h0,   0, 1, 32'h28,  0, 0, 1, 2);

    nps = 0; tgt = 0; st = 0; rdy = 1;
    nps2 = 0; tgt2 = 0; st2 = 0; rdy2 = 1;

    // Initial reset with outputs checked while held.
    #2;
    check("init_rst_pc", pc, 32'h0);
    check("init_rst_valid", {31'b0, valid}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // ---- table-driven directed run ----
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].nps, vecs[i].tgt, vecs[i].st, vecs[i].rdy);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
      check($sformatf("vec%0d_flush_ifid", i), {31'b0, f_ifid}, {31'b0, vecs[i].flush});
      check($sformatf("vec%0d_flush_idex", i), {31'b0, f_idex}, {31'b0, vecs[i].flush});
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      check($sformatf("vec%0d_cnt", i), {16'b0, cnt}, {16'b0, vecs[i].cnt});
    end

    // ---- reset pulsed during HALT, then fetch restarts ----
    pulse_reset();
    apply(0, 32'h0, 0, 1);
    check("post_rst_boot_valid", {31'b0, valid}, 32'h0);
    check("post_rst_boot_pc", pc, 32'h0);
    apply(0, 32'h0, 0, 1);
    check("post_rst_run_valid", {31'b0, valid}, 32'h1);
    check("post_rst_pc0", pc, 32'h0);
    apply(0, 32'h0, 0, 1);
    check("post_rst_pc4", pc, 32'h4);

    // ---- randomized run against the reference model ----
    pulse_reset();
    m_boot = 1; m_halt = 0; m_err = 0; m_pc = 32'h0; m_cnt = 0;
    begin
      int halt_age = 0;
      for (int i = 0; i < 600; i++) begin
        logic        r_nps, r_st, r_rdy;
        logic [31:0] r_tgt;
        bit          e_valid, e_flush;
        if (m_halt && halt_age > 3) begin
          pulse_reset();
          m_boot = 1; m_halt = 0; m_err = 0; m_pc = 32'h0; m_cnt = 0;
          halt_age = 0;
        end
        r_nps = ($urandom_range(0, 5) == 0);
        r_st  = ($urandom_range(0, 3) == 0);
        r_rdy = ($urandom_range(0, 3) != 0);
        r_tgt = $urandom() & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) r_tgt = 32'hFFFF_FFF8;
        if ($urandom_range(0, 39) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
        apply(r_nps, r_tgt, r_st, r_rdy);

        e_valid = !m_boot && !m_halt;
        e_flush = e_valid && r_nps;
        check("rnd_pc", pc, m_pc);
        check("rnd_valid", {31'b0, valid}, {31'b0, e_valid});
        check("rnd_flush_ifid", {31'b0, f_ifid}, {31'b0, e_flush});
        check("rnd_flush_idex", {31'b0, f_idex}, {31'b0, e_flush});
        check("rnd_err", {31'b0, err}, {31'b0, m_err});
        check("rnd_cnt", {16'b0, cnt}, m_cnt);

        // Model update for the coming rising edge.
        if (m_boot) begin
          m_boot = 0;
        end else if (m_halt) begin
          halt_age++;
        end else if (r_nps) begin
          if (r_tgt % 4 != 0) begin
            m_err = 1;
            m_halt = 1;
          end else begin
            m_pc = r_tgt;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
          end
        end else if (!r_st && r_rdy) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end

    // ---- narrow counter saturation and PC wrap (second instance) ----
    pulse_reset();
    apply2(0, 32'h0, 0, 1);
    check("n2_boot_valid", {31'b0, valid2}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      apply2(1, 32'h40, 0, 1);
      check($sformatf("n2_redir%0d_flush", k), {31'b0, f_ifid2}, 32'h1);
    end
    apply2(0, 32'h0, 1, 1);
    check("n2_cnt_sat", {30'b0, cnt2}, 32'h3);
    check("n2_pc_target", pc2, 32'h40);
    apply2(1, 32'hFFFF_FFFC, 0, 1);
    apply2(0, 32'h0, 0, 1);
    check("n2_pc_top", pc2, 32'hFFFF_FFFC);
    apply2(0, 32'h0, 0, 1);
    check("n2_pc_wrap", pc2, 32'h0);
    check("n2_cnt_still_sat", {30'b0, cnt2}, 32'h3);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_redirect_unit.md
FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16: width of the redirect counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port NextPCSrc, input, 1: branch/jump taken, from the branch unit in EX.
REQ-006 SHALL have port BranchTarget, input, 32: redirect target, from the EX-stage ALU.
REQ-007 SHALL have port Stall, input, 1: load-use stall from the hazard unit; freezes PC.
REQ-008 SHALL have port IMemReady, input, 1: instruction memory accepts the current fetch.
REQ-009 SHALL have port PC, output, 32: current fetch address.
REQ-010 SHALL have port PCValid, output, 1: fetch request valid.
REQ-011 SHALL have port FlushIFID, output, 1: clear the IF/ID register.
REQ-012 SHALL have port FlushIDEX, output, 1: clear the ID/EX register.
REQ-013 SHALL have port MisalignErr, output, 1: sticky misaligned-target flag.
REQ-014 SHALL have port RedirectCount, output, CNT_W: number of taken redirects.

Function
REQ-015 SHALL implement the FSM states BOOT, RUN and HALT.
REQ-016 SHALL spend exactly one cycle in BOOT after rst_n deasserts (PCValid=0), then enter RUN.
REQ-017 SHALL hold PCValid=1 in RUN and PCValid=0 in BOOT and HALT.
REQ-018 SHALL define a taken redirect as NextPCSrc=1 while in RUN.
REQ-019 SHALL, on a taken redirect with BranchTarget[1:0]=00, load PC<=BranchTarget at the next edge and increment RedirectCount.
REQ-020 SHALL assert FlushIFID=1 and FlushIDEX=1 combinationally in the same cycle as a taken redirect; both SHALL be 0 otherwise.
REQ-021 SHALL give a redirect priority over Stall and over IMemReady=0; the pending fetch is abandoned.
REQ-022 SHALL keep PC unchanged in RUN when there is no redirect and either Stall=1 or IMemReady=0.
REQ-023 SHALL advance PC<=PC+4 in RUN when there is no redirect, Stall=0 and IMemReady=1, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-024 SHALL keep PC stable while PCValid=1 and IMemReady=0, except when a redirect occurs.
REQ-025 SHALL, on a taken redirect with BranchTarget[1:0]!=00:
- assert the flushes (per REQ-020);
- leave PC unchanged;
- set MisalignErr=1;
- enter HALT at the next edge.
REQ-026 SHALL, in HALT, ignore all inputs, hold PC, keep flushes at 0, and leave HALT only through reset.
REQ-027 SHALL ignore NextPCSrc in BOOT and HALT (no flush, no count).
REQ-028 SHALL saturate RedirectCount at all-ones; it never wraps.

Reset
REQ-029 SHALL, while rst_n=0 and independent of clk, force:
- PC=RESET_PC, PCValid=0, FlushIFID=0, FlushIDEX=0;
- MisalignErr=0, RedirectCount=0;
- state=BOOT.
REQ-030 SHALL abort any operation in progress (including HALT) on rst_n assertion mid-cycle, and restart from BOOT on release.

Verification
REQ-031 Reset release -> PCValid=0 for one cycle; then PC=0,4,8,... per cycle with Stall=0 and IMemReady=1.
REQ-032 PC=0x10, NextPCSrc=1, BranchTarget=0x100, Stall=1 -> flushes=1 that cycle; next PC=0x100; RedirectCount=1.
REQ-033 PC=0x20, IMemReady=0 for 3 cycles -> PC=0x20 held and PCValid=1 throughout; then 0x24 after IMemReady=1.
REQ-034 NextPCSrc=1, BranchTarget=0x102 -> flushes=1; PC unchanged; MisalignErr=1; PCValid=0 afterwards; later NextPCSrc=1 -> no flush.
REQ-035 With CNT_W=2, five redirects -> RedirectCount=3; PC=0xFFFF_FFFC advancing -> PC=0x0.
REQ-036 rst_n pulsed low mid-cycle during HALT -> outputs take reset values immediately; normal fetch resumes from RESET_PC.
